// File: rtl/text_console_writer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// text_console_writer
//
// Writes characters into the 80x60 screen character RAM that the VGA text
// display scans out. The byte stream from the core arrives over a
// valid/ready handshake. Printable codes are written at the cursor. Control
// codes move the cursor, clear the screen or trigger a scroll. This block
// owns port B of the dual-port screen RAM.
//
// Ports
//   clk_50MHz   in   system clock, the only clock
//   reset       in   synchronous, active-low reset
//   in_valid    in   character offered by the core
//   in_char     in   character code
//   in_ready    out  writer accepts in_char this cycle
//   wr_en       out  screen RAM write strobe
//   wr_col      out  write column (0..79)
//   wr_row      out  write row (0..59)
//   wr_char     out  write data
//   rd_col      out  read column
//   rd_row      out  read row
//   rd_char     in   read data, valid one cycle after rd_col/rd_row
//   cursor_col  out  current cursor column
//   cursor_row  out  current cursor row
//   busy        out  high while clearing or scrolling
//
// State             | meaning
// ------------------+------------------------------------------------------
// ST_RESET          | held in reset, all outputs 0; leaves into ST_CLEAR
// ST_CLEAR          | writing BLANK to all 4800 cells, row-major
// ST_IDLE           | in_ready=1, accepting characters
// ST_SCROLL_WAIT    | one cycle for the write at (59,79) before the copy
// ST_SCROLL_COPY    | reading rows 1..59 and writing them one row up
// ST_SCROLL_CLEAR   | writing BLANK across row 59
// ----------------------------------------------------------------------------
module text_console_writer (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       wr_en,
    output logic [6:0] wr_col,
    output logic [6:0] wr_row,
    output logic [7:0] wr_char,
    output logic [6:0] rd_col,
    output logic [6:0] rd_row,
    input  logic [7:0] rd_char,
    output logic [6:0] cursor_col,
    output logic [6:0] cursor_row,
    output logic       busy
);

    localparam int          COLS  = 80;
    localparam int          ROWS  = 60;
    localparam logic [7:0]  BLANK = 8'h20;

    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [6:0]  LAST_ROW = 7'(ROWS - 1);

    // Down-counter loads; each phase ends when the counter reaches zero.
    localparam logic [12:0] CLEAR_LOAD = 13'(COLS * ROWS - 1);
    localparam logic [12:0] COPY_LOAD  = 13'(COLS * (ROWS - 1));
    localparam logic [12:0] ROW_LOAD   = 13'(COLS - 1);

    localparam logic [7:0]  CH_BS = 8'h08;
    localparam logic [7:0]  CH_LF = 8'h0A;
    localparam logic [7:0]  CH_FF = 8'h0C;
    localparam logic [7:0]  CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_CLEAR,
        ST_IDLE,
        ST_SCROLL_WAIT,
        ST_SCROLL_COPY,
        ST_SCROLL_CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] cells_q, cells_d;
    logic [6:0]  cur_col_q, cur_col_d;
    logic [6:0]  cur_row_q, cur_row_d;
    logic        wr_en_q, wr_en_d;
    logic [6:0]  wr_col_q, wr_col_d;
    logic [6:0]  wr_row_q, wr_row_d;
    logic [7:0]  wr_char_q, wr_char_d;
    logic        copy_q, copy_d;
    logic [6:0]  rd_col_q, rd_col_d;
    logic [6:0]  rd_row_q, rd_row_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;

    logic        start_clear;
    logic        start_copy;
    logic        printable;

    assign printable = (in_char >= 8'h20) && (in_char <= 8'h7E);

    always_comb begin
        state_d     = state_q;
        cells_d     = cells_q;
        cur_col_d   = cur_col_q;
        cur_row_d   = cur_row_q;
        wr_en_d     = 1'b0;
        wr_col_d    = wr_col_q;
        wr_row_d    = wr_row_q;
        wr_char_d   = wr_char_q;
        copy_d      = 1'b0;
        rd_col_d    = rd_col_q;
        rd_row_d    = rd_row_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        start_clear = 1'b0;
        start_copy  = 1'b0;

        case (state_q)
            ST_RESET: begin
                start_clear = 1'b1;
            end

            ST_CLEAR: begin
                if (cells_q == '0) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    cur_col_d  = '0;
                    cur_row_d  = '0;
                end else begin
                    cells_d   = cells_q - 13'd1;
                    wr_en_d   = 1'b1;
                    wr_char_d = BLANK;
                    if (wr_col_q == LAST_COL) begin
                        wr_col_d = '0;
                        wr_row_d = wr_row_q + 7'd1;
                    end else begin
                        wr_col_d = wr_col_q + 7'd1;
                    end
                end
            end

            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_col_d  = cur_col_q;
                        wr_row_d  = cur_row_q;
                        wr_char_d = in_char;
                        if (cur_col_q == LAST_COL) begin
                            cur_col_d = '0;
                            if (cur_row_q == LAST_ROW) begin
                                // The character's own write must land before
                                // the copy starts reading, so hold one cycle.
                                state_d    = ST_SCROLL_WAIT;
                                in_ready_d = 1'b0;
                                busy_d     = 1'b1;
                            end else begin
                                cur_row_d = cur_row_q + 7'd1;
                            end
                        end else begin
                            cur_col_d = cur_col_q + 7'd1;
                        end
                    end else begin
                        case (in_char)
                            CH_LF: begin
                                cur_col_d = '0;
                                if (cur_row_q == LAST_ROW) begin
                                    start_copy = 1'b1;
                                end else begin
                                    cur_row_d = cur_row_q + 7'd1;
                                end
                            end
                            CH_CR: begin
                                cur_col_d = '0;
                            end
                            CH_BS: begin
                                if (cur_col_q != '0) begin
                                    cur_col_d = cur_col_q - 7'd1;
                                end
                            end
                            CH_FF: begin
                                start_clear = 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            ST_SCROLL_WAIT: begin
                start_copy = 1'b1;
            end

            ST_SCROLL_COPY: begin
                if (cells_q == '0) begin
                    // Pipeline drained; start blanking the bottom row.
                    state_d   = ST_SCROLL_CLEAR;
                    cells_d   = ROW_LOAD;
                    wr_en_d   = 1'b1;
                    wr_row_d  = LAST_ROW;
                    wr_col_d  = '0;
                    wr_char_d = BLANK;
                end else begin
                    // The cell addressed this cycle is written next cycle,
                    // one row up, with rd_char passed straight through.
                    cells_d  = cells_q - 13'd1;
                    wr_en_d  = 1'b1;
                    copy_d   = 1'b1;
                    wr_row_d = rd_row_q - 7'd1;
                    wr_col_d = rd_col_q;
                    if (cells_q != 13'd1) begin
                        if (rd_col_q == LAST_COL) begin
                            rd_col_d = '0;
                            rd_row_d = rd_row_q + 7'd1;
                        end else begin
                            rd_col_d = rd_col_q + 7'd1;
                        end
                    end
                end
            end

            ST_SCROLL_CLEAR: begin
                if (cells_q == '0) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    cells_d   = cells_q - 13'd1;
                    wr_en_d   = 1'b1;
                    wr_col_d  = wr_col_q + 7'd1;
                    wr_char_d = BLANK;
                end
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase

        if (start_clear) begin
            state_d    = ST_CLEAR;
            cells_d    = CLEAR_LOAD;
            wr_en_d    = 1'b1;
            wr_col_d   = '0;
            wr_row_d   = '0;
            wr_char_d  = BLANK;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
        end

        if (start_copy) begin
            state_d    = ST_SCROLL_COPY;
            cells_d    = COPY_LOAD;
            rd_col_d   = '0;
            rd_row_d   = 7'd1;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            cells_q    <= '0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_col_q   <= '0;
            wr_row_q   <= '0;
            wr_char_q  <= '0;
            copy_q     <= 1'b0;
            rd_col_q   <= '0;
            rd_row_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cells_q    <= cells_d;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
            wr_en_q    <= wr_en_d;
            wr_col_q   <= wr_col_d;
            wr_row_q   <= wr_row_d;
            wr_char_q  <= wr_char_d;
            copy_q     <= copy_d;
            rd_col_q   <= rd_col_d;
            rd_row_q   <= rd_row_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Copy data arrives from the RAM in the same cycle it has to be written,
    // so write data bypasses its register only during copy writes.
    assign wr_char    = copy_q ? rd_char : wr_char_q;
    assign wr_en      = wr_en_q;
    assign wr_col     = wr_col_q;
    assign wr_row     = wr_row_q;
    assign rd_col     = rd_col_q;
    assign rd_row     = rd_row_q;
    assign cursor_col = cur_col_q;
    assign cursor_row = cur_row_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
`timescale 1ns/1ps
module tb_text_console_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       wr_en;
    logic [6:0] wr_col;
    logic [6:0] wr_row;
    logic [7:0] wr_char;
    logic [6:0] rd_col;
    logic [6:0] rd_row;
    logic [7:0] rd_char = 8'h00;
    logic [6:0] cursor_col;
    logic [6:0] cursor_row;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // Screen RAM as seen through port B, and the reference screen.
    logic [7:0] ram [0:4799];
    logic [7:0] scr [0:4799];
    int m_row = 0;
    int m_col = 0;

    int         cyc = 0;
    int         wq_addr [$];
    logic [7:0] wq_char [$];
    int         wq_cyc  [$];

    text_console_writer dut (
        .clk_50MHz  (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_char    (wr_char),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_char    (rd_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_row < 7'd60 && wr_col < 7'd80)
                ram[int'(wr_row) * 80 + int'(wr_col)] <= wr_char;
            wq_addr.push_back(int'(wr_row) * 80 + int'(wr_col));
            wq_char.push_back(wr_char);
            wq_cyc.push_back(cyc);
        end
        if (rd_row < 7'd60 && rd_col < 7'd80)
            rd_char <= ram[int'(rd_row) * 80 + int'(rd_col)];
        else
            rd_char <= 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic log_clear();
        wq_addr.delete();
        wq_char.delete();
        wq_cyc.delete();
    endtask

    task automatic model_scroll();
        for (int i = 0; i < 4720; i++) scr[i] = scr[i + 80];
        for (int i = 4720; i < 4800; i++) scr[i] = 8'h20;
    endtask

    task automatic model_blank();
        for (int i = 0; i < 4800; i++) scr[i] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_char(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[m_row * 80 + m_col] = ch;
            m_col++;
            if (m_col == 80) begin
                m_col = 0;
                if (m_row == 59) model_scroll();
                else m_row++;
            end
        end else if (ch == 8'h0A) begin
            m_col = 0;
            if (m_row == 59) model_scroll();
            else m_row++;
        end else if (ch == 8'h0D) begin
            m_col = 0;
        end else if (ch == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (ch == 8'h0C) begin
            model_blank();
        end
    endtask

    // Returns at #1 after the transfer edge, i.e. in the cycle after the transfer.
    task automatic send(input logic [7:0] ch);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_char  = ch;
        while (in_ready !== 1'b1 && n < 10000) begin
            tick();
            n++;
        end
        chk("send_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        model_char(ch);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 10000) begin
            tick();
            n++;
        end
    endtask

    task automatic compare_screen(input string tag);
        int bad;
        tick();
        bad = 0;
        for (int i = 0; i < 4800; i++) if (ram[i] !== scr[i]) bad++;
        chk({tag, "_screen"}, bad, 0);
        chk({tag, "_cur_row"}, cursor_row, m_row);
        chk({tag, "_cur_col"}, cursor_col, m_col);
    endtask

    // Called at #1 inside cycle 0 of a CLEAR.
    task automatic check_clear(input string tag);
        int n;
        int c0;
        int bad;
        log_clear();
        c0 = cyc;
        chk({tag, "_busy0"}, busy, 1);
        chk({tag, "_ready0"}, in_ready, 0);
        wait_ready(n);
        chk({tag, "_ready_cycle"}, n, 4800);
        chk({tag, "_nwrites"}, wq_addr.size(), 4800);
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != i || wq_char[i] !== 8'h20 || wq_cyc[i] != c0 + i) bad++;
        chk({tag, "_order"}, bad, 0);
        chk({tag, "_busy_end"}, busy, 0);
        model_blank();
        compare_screen(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_cursor"}, {cursor_row, cursor_col}, 0);
        chk({tag, "_wr_addr"}, {wr_row, wr_col}, 0);
        chk({tag, "_wr_char"}, wr_char, 0);
        chk({tag, "_rd_addr"}, {rd_row, rd_col}, 0);
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0: return 8'h0A;
            1: return 8'h0D;
            2: return 8'h08;
            3: return ($urandom_range(0, 1) == 0) ? 8'h7F : 8'(8'h80 + $urandom_range(0, 127));
            default: return 8'($urandom_range(32, 126));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        int bad;
        logic [7:0] v;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_char  = 8'h00;
        repeat (3) tick();
        chk_zero("reset");

        // Power-on clear
        reset = 1'b1;
        tick();
        check_clear("rst_clear");

        // Back-to-back "AB", then CR LF
        log_clear();
        send(8'h41);
        send(8'h42);
        tick();
        tick();
        chk("ab_nwrites", wq_addr.size(), 2);
        chk("ab_w0", {wq_addr[0], wq_char[0]}, {32'd0, 8'h41});
        chk("ab_w1", {wq_addr[1], wq_char[1]}, {32'd1, 8'h42});
        chk("ab_consec", wq_cyc[1] - wq_cyc[0], 1);
        chk("ab_cursor", {cursor_row, cursor_col}, {7'd0, 7'd2});
        send(8'h0D);
        send(8'h0A);
        tick();
        tick();
        chk("crlf_nwrites", wq_addr.size(), 2);
        chk("crlf_cursor", {cursor_row, cursor_col}, {7'd1, 7'd0});
        compare_screen("ab");

        // 80 printables across row 0, then BS at column 0
        send(8'h0C);
        check_clear("ff1");
        log_clear();
        for (int i = 0; i < 80; i++) send(8'($urandom_range(32, 126)));
        tick();
        chk("row_nwrites", wq_addr.size(), 80);
        chk("row_last_addr", wq_addr[wq_addr.size() - 1], 79);
        chk("row_cursor", {cursor_row, cursor_col}, {7'd1, 7'd0});
        send(8'h08);
        tick();
        chk("bs_col0", {cursor_row, cursor_col}, {7'd1, 7'd0});
        compare_screen("row");

        // LF at (59,5) with a patterned RAM
        send(8'h0C);
        check_clear("ff2");
        for (int i = 0; i < 59; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
        tick();
        chk("lf_pre_cursor", {cursor_row, cursor_col}, {7'd59, 7'd5});
        for (int r = 0; r < 60; r++) begin
            v = 8'h30 + 8'(r);
            for (int c = 0; c < 80; c++) begin
                ram[r * 80 + c] = v;
                scr[r * 80 + c] = v;
            end
        end
        log_clear();
        send(8'h0A);
        c0 = cyc;
        chk("lf_busy0", {busy, in_ready}, 2'b10);
        chk("lf_rd0", {rd_row, rd_col}, {7'd1, 7'd0});
        wait_ready(n);
        chk("lf_ready_cycle", n, 4801);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            if (ram[58 * 80 + c] !== 8'h30 + 8'd59) bad++;
            if (ram[c] !== 8'h30 + 8'd1) bad++;
            if (ram[59 * 80 + c] !== 8'h20) bad++;
        end
        chk("lf_rows", bad, 0);
        chk("lf_cursor", {cursor_row, cursor_col}, {7'd59, 7'd0});
        chk("lf_nwrites", wq_addr.size(), 4800);
        chk("lf_first_wr", wq_cyc[0] - c0, 1);
        chk("lf_last_wr", wq_cyc[wq_cyc.size() - 1] - c0, 4800);
        chk("lf_rd_hold", {rd_row, rd_col}, {7'd59, 7'd79});
        compare_screen("lf");

        // Printable at (59,79)
        send(8'h0C);
        check_clear("ff3");
        for (int i = 0; i < 59; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'($urandom_range(32, 126)));
        tick();
        chk("z_pre_cursor", {cursor_row, cursor_col}, {7'd59, 7'd79});
        send(8'h5A);
        chk("z_write", {wr_en, wr_row, wr_col, wr_char}, {1'b1, 7'd59, 7'd79, 8'h5A});
        chk("z_busy", {busy, in_ready}, 2'b10);
        wait_ready(n);
        chk("z_ready_cycle", n, 4802);
        chk("z_moved", ram[58 * 80 + 79], 8'h5A);
        chk("z_blank", ram[59 * 80 + 79], 8'h20);
        chk("z_cursor", {cursor_row, cursor_col}, {7'd59, 7'd0});
        compare_screen("z");

        // Random stream from the top, then a short one near the bottom
        send(8'h0C);
        check_clear("ff4");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
            send(rand_char());
        end
        wait_ready(n);
        compare_screen("rand1");
        while (m_row < 57) send(8'h0A);
        for (int i = 0; i < 40; i++) send(rand_char());
        wait_ready(n);
        chk("rand2_ready", in_ready, 1);
        compare_screen("rand2");

        // FF then reset pulse at CLEAR cycle 100
        send(8'h0C);
        repeat (100) tick();
        reset = 1'b0;
        tick();
        chk_zero("abort");
        reset = 1'b1;
        tick();
        check_clear("abort_clear");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Writes characters into the 80×60 screen character RAM that the VGA text display scans out. It accepts a byte stream from the RISC-V core over a valid/ready handshake and interprets printable and control characters. It maintains the cursor, clears the screen, and scrolls by copying RAM contents up one row. It owns port B of the dual-port screen RAM; the VGA scan-out owns port A.

## Interface
- COLS, 80, characters per row (640/8)
- ROWS, 60, character rows (480/8)
- BLANK, 8'h20, fill code for cleared cells
- clk_50MHz  in  1  system clock; the only clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  character offered by the core
- in_char  in  8  character code
- in_ready  out  1  writer can accept `in_char` this cycle
- wr_en  out  1  screen RAM write strobe
- wr_col  out  7  write column (0..79)
- wr_row  out  7  write row (0..59)
- wr_char  out  8  write data
- rd_col  out  7  read column
- rd_row  out  7  read row
- rd_char  in  8  read data, valid one cycle after `rd_col`/`rd_row` (synchronous RAM)
- cursor_col  out  7  current cursor column
- cursor_row  out  7  current cursor row
- busy  out  1  high in CLEAR or SCROLL

## Operation
- All outputs are registered. While `reset`=0, every output is 0.
- The first cycle after `reset` rises enters CLEAR.
- States:
  - IDLE: `in_ready`=1.
  - CLEAR: writes BLANK to all 4800 cells in row-major order, (0,0) to (59,79). Then cursor=(0,0) and → IDLE.
  - SCROLL_COPY: moves rows 1..59 up one row.
  - SCROLL_CLEAR: fills row 59 with BLANK, then → IDLE.
- A transfer occurs on `in_valid` && `in_ready`. Its effect depends on `in_char`:
  - 0x20–0x7E: next cycle `wr_en`=1 at the cursor cell with `wr_char`=`in_char`. The cursor advances one column.
  - Column wrap: if the column was 79, the column becomes 0 and the row increments.
  - Row overflow: if the row was 59, the row stays 59 and the state goes → SCROLL_COPY.
  - 0x0A (LF): column becomes 0, row increments; row 59 → SCROLL_COPY with row kept at 59. No write.
  - 0x0D (CR): column becomes 0. No write.
  - 0x08 (BS): column decrements if greater than 0; otherwise no change. No write.
  - 0x0C (FF): → CLEAR.
  - All other codes are consumed with no effect.
- SCROLL_COPY pipeline: the read address steps through (1,0)..(59,79) row-major, one cell per cycle. Each `rd_char` is written one cycle later to the same column, one row up.
- SCROLL_CLEAR writes BLANK to (59,0)..(59,79).
- `in_ready`=0 and `busy`=1 in every state other than IDLE.
- `rd_col`/`rd_row` hold their last value when not in SCROLL_COPY.
- `cursor_col`/`cursor_row` update in the cycle following the transfer.

## Timing
- Printable throughput is 1 character per cycle with no scroll. The write strobe comes 1 cycle after the transfer.
- Entering CLEAR (cycle 0 = first cycle in CLEAR):
  - writes occur in cycles 0..4799;
  - `in_ready`=1 at cycle 4800.
- Entering SCROLL_COPY (cycle 0):
  - reads are issued in cycles 0..4719;
  - copy writes occur in cycles 1..4720;
  - BLANK writes to row 59 occur in cycles 4721..4800;
  - `in_ready`=1 at cycle 4801.
- The scroll triggered by a printable at (59,79) comes after that character's write. The write is in the cycle before SCROLL_COPY cycle 0, so it is copied to row 58.
- Reset low mid-operation (CLEAR or SCROLL) aborts in the next cycle: outputs go to 0 and the cursor to (0,0). After release a full CLEAR runs.
- `in_valid` held during busy is not accepted. The byte stays pending until `in_ready`=1.

## Test plan
- Reset release → 4800 writes of 0x20 covering (0,0)..(59,79), `in_ready` rising on cycle 4800, cursor (0,0).
- Stream "AB" back-to-back → writes 0x41 at (0,0) and 0x42 at (0,1) on consecutive cycles; cursor (0,2). Then 0x0D, 0x0A → cursor (1,0) with no writes.
- 80 printable chars from (0,0) → last write at (0,79), cursor (1,0). A following 0x08 leaves the cursor at (1,0).
- Cursor (59,5), send 0x0A with a RAM model holding row r = char r → after 4801 cycles:
  - row 58 = char 59, row 0 = char 1, row 59 = 0x20;
  - cursor (59,0).
- 0x5A at (59,79) → 0x5A lands at (58,79) after scroll, and (59,79)=0x20.
- 0x0C mid-screen, then reset pulled low at CLEAR cycle 100 for 1 cycle → all outputs 0, then a fresh 4800-write CLEAR.
